// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath widths, ALU opcodes, forwarding selects.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // ALU opcode encoding shared with the ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Which source feeds a register operand
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: EX/MEM beats MEM/WB beats register file; x0 never forwards.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0]    src_addr,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               exmem_reg_write,
  input  logic [RA_W-1:0]    exmem_rd_addr,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RA_W-1:0]    memwb_rd_addr,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    data,
  output riscv_pkg::fwd_sel_e sel
);

  logic src_nz;
  assign src_nz = (src_addr != '0);

  // Priority select of the youngest in-flight producer of src_addr
  always_comb begin
    sel  = riscv_pkg::FWD_RF;
    data = rf_data;
    if (src_nz && exmem_reg_write && (exmem_rd_addr == src_addr)) begin
      sel  = riscv_pkg::FWD_EXMEM;
      data = exmem_result;
    end else if (src_nz && memwb_reg_write && (memwb_rd_addr == src_addr)) begin
      sel  = riscv_pkg::FWD_MEMWB;
      data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with handshake, flush, and forwarded ALU operand selection.
module id_ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_alu_control,
  input  logic            in_use_imm,
  input  logic            in_use_pc,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] store_data,
  output logic [RA_W-1:0] rd_addr,
  output logic            reg_write,
  output logic [XLEN-1:0] pc
);

  import riscv_pkg::*;

  logic            vld;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic [3:0]      alu_q;
  logic            use_imm_q, use_pc_q, rw_q;
  logic            load;

  assign in_ready = !vld || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Valid bit: flush beats load, load beats drain; stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         vld <= 1'b0;
    else if (flush)     vld <= 1'b0;
    else if (load)      vld <= 1'b1;
    else if (out_ready) vld <= 1'b0;
  end

  // Instruction field bank, captured only on an accepted, unflushed load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_q       <= '0;
      alu_q      <= ALU_ADD;
      use_imm_q  <= 1'b0;
      use_pc_q   <= 1'b0;
      rw_q       <= 1'b0;
    end else if (load) begin
      pc_q       <= in_pc;
      rs1_data_q <= in_rs1_data;
      rs2_data_q <= in_rs2_data;
      imm_q      <= in_imm;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rd_q       <= in_rd_addr;
      alu_q      <= in_alu_control;
      use_imm_q  <= in_use_imm;
      use_pc_q   <= in_use_pc;
      rw_q       <= in_reg_write;
    end
  end

  // Forwarding is re-evaluated every cycle so a stalled instruction
  // sees results that retire while it waits.
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  fwd_sel_e        unused_rs1_sel, unused_rs2_sel;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .src_addr        (rs1_addr_q),
    .rf_data         (rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .data            (fwd_rs1),
    .sel             (unused_rs1_sel)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .src_addr        (rs2_addr_q),
    .rf_data         (rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .data            (fwd_rs2),
    .sel             (unused_rs2_sel)
  );

  // Bubbles present a harmless ADD 0,0 with no writeback
  always_comb begin
    operand_a   = '0;
    operand_b   = '0;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    if (vld) begin
      operand_a   = use_pc_q  ? pc_q  : fwd_rs1;
      operand_b   = use_imm_q ? imm_q : fwd_rs2;
      alu_control = alu_q;
      reg_write   = rw_q;
    end
  end

  assign out_valid  = vld;
  assign store_data = fwd_rs2;
  assign rd_addr    = rd_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding, stall, flush, streaming.
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]  in_alu_control;
  logic        in_use_imm, in_use_pc, in_reg_write, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] operand_a, operand_b, store_data, pc;
  logic [3:0]  alu_control;
  logic [4:0]  rd_addr;
  logic        reg_write;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_alu_control(in_alu_control),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_reg_write(in_reg_write),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
    .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] p, input logic [4:0] r1a, input logic [31:0] r1d,
                           input logic [4:0] r2a, input logic [31:0] r2d, input logic [4:0] rd,
                           input logic [31:0] imm, input logic [3:0] alu,
                           input logic ui, input logic up, input logic rw);
    in_pc = p; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
    in_rd_addr = rd; in_imm = imm; in_alu_control = alu;
    in_use_imm = ui; in_use_pc = up; in_reg_write = rw;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_instr(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    exmem_reg_write = 1'b0; exmem_rd_addr = 5'd0; exmem_result = 32'h0;
    memwb_reg_write = 1'b0; memwb_rd_addr = 5'd0; memwb_result = 32'h0;

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_pc", pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic load: rs1=5, imm=7, use_imm
    set_instr(32'h100, 5'd1, 32'd5, 5'd2, 32'd9, 5'd4, 32'd7, 4'd0, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    cyc();
    chk("ld_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_operand_a", operand_a, 32'd5);
    chk("ld_operand_b", operand_b, 32'd7);
    chk("ld_pc", pc, 32'h100);
    chk("ld_rd_addr", {27'd0, rd_addr}, 32'd4);
    chk("ld_reg_write", {31'd0, reg_write}, 32'd1);
    chk("ld_store_data", store_data, 32'd9);

    // forwarding priority on rs1=3, held by a stall
    set_instr(32'h104, 5'd3, 32'h11, 5'd5, 32'h22, 5'd6, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd3; memwb_result = 32'h0000_1234;
    #1;
    chk("fwd_both_a", operand_a, 32'hAAAA_0000);
    chk("fwd_both_b", operand_b, 32'h22);
    chk("fwd_alu", {28'd0, alu_control}, 32'd1);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb_a", operand_a, 32'h0000_1234);
    memwb_reg_write = 1'b0;
    #1;
    chk("fwd_rf_a", operand_a, 32'h11);

    // x0 never forwarded; rs2 forwarding and use_pc
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h108, 5'd0, 32'h77, 5'd5, 32'h55, 5'd1, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'hDEAD_BEEF;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 32'hCAFE_F00D;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("x0_operand_a", operand_a, 32'h77);
    chk("x0_operand_b", operand_b, 32'h55);
    exmem_rd_addr = 5'd5;
    #1;
    chk("fwd_rs2_b", operand_b, 32'hDEAD_BEEF);
    chk("fwd_rs2_store", store_data, 32'hDEAD_BEEF);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // stall: held instruction S, incoming N waits
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    set_instr(32'h200, 5'd1, 32'h10, 5'd6, 32'h66, 5'd7, 32'h0, 4'd2, 1'b0, 1'b0, 1'b1);
    cyc();
    out_ready = 1'b0;
    set_instr(32'h300, 5'd2, 32'h31, 5'd3, 32'h32, 5'd8, 32'h0, 4'd3, 1'b0, 1'b0, 1'b1);
    #1;
    chk("stl1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stl1_pc", pc, 32'h200);
    chk("stl1_operand_a", operand_a, 32'h10);
    cyc();
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd6; memwb_result = 32'h0000_BEEF;
    #1;
    chk("stl2_store_data", store_data, 32'h0000_BEEF);
    chk("stl2_operand_b", operand_b, 32'h0000_BEEF);
    chk("stl2_pc", pc, 32'h200);
    cyc();
    memwb_reg_write = 1'b0;
    chk("stl3_pc", pc, 32'h200);
    chk("stl3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stl3_alu", {28'd0, alu_control}, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("rel_pc", pc, 32'h300);
    chk("rel_operand_a", operand_a, 32'h31);

    // flush while stalled with a pending input
    out_ready = 1'b0; in_valid = 1'b1; flush = 1'b1;
    set_instr(32'h400, 5'd1, 32'h41, 5'd2, 32'h42, 5'd9, 32'h0, 4'd4, 1'b0, 1'b0, 1'b1);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_reg_write", {31'd0, reg_write}, 32'd0);
    chk("fl_alu", {28'd0, alu_control}, 32'd0);
    chk("fl_operand_a", operand_a, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);
    chk("fl_pc_not_loaded", pc, 32'h300);

    // back-to-back: 8 instructions, no bubbles
    in_valid = 1'b1;
    set_instr(32'h1000, 5'd1, 32'h1, 5'd2, 32'h0, 5'd3, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("b2b_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("b2b_pc_%0d", i), pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("b2b_opa_%0d", i), operand_a, 32'(i * 17 + 1));
      if (i < 7)
        set_instr(32'h1000 + 32'(4 * (i + 1)), 5'd1, 32'((i + 1) * 17 + 1), 5'd2, 32'h0,
                  5'd3, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1);
      else
        in_valid = 1'b0;
    end
    cyc();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // reset mid-stream while stalled with a valid instruction
    in_valid = 1'b1; out_ready = 1'b0;
    set_instr(32'h500, 5'd1, 32'h51, 5'd2, 32'h52, 5'd10, 32'h0, 4'd5, 1'b0, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_use_pc", operand_a, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mrst_alu", {28'd0, alu_control}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_pc", pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and execute-operand selector that sits directly upstream of the ALU. It captures decoded instruction fields under a valid/ready handshake and holds them through downstream stalls. It resolves register-operand forwarding from the EX/MEM and MEM/WB stages, then drives `operand_a`, `operand_b` and `alu_control` into the ALU. Flushes from branch resolution turn the stage into a bubble.

## Interface
- `XLEN`, default 32: datapath width.
- `RA_W`, default 5: register-address width.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: decode presents a valid instruction.
- `in_ready` output 1: stage accepts this cycle.
- `in_pc` input XLEN: instruction PC.
- `in_rs1_data`, `in_rs2_data` input XLEN: register-file read data.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` input RA_W: register indices.
- `in_imm` input XLEN: sign-extended immediate.
- `in_alu_control` input 4: ALU opcode, using the ALU's 4-bit encoding (ADD=0 … SLTU=9).
- `in_use_imm` input 1: operand B is the immediate.
- `in_use_pc` input 1: operand A is the PC.
- `in_reg_write` input 1: instruction writes `rd`.
- `flush` input 1: squash held and incoming instruction.
- `exmem_reg_write` input 1, `exmem_rd_addr` input RA_W, `exmem_result` input XLEN: EX/MEM forwarding source.
- `memwb_reg_write` input 1, `memwb_rd_addr` input RA_W, `memwb_result` input XLEN: MEM/WB forwarding source.
- `out_valid` output 1: EX outputs hold a valid instruction.
- `out_ready` input 1: downstream consumes this cycle.
- `operand_a`, `operand_b` output XLEN: ALU operands.
- `alu_control` output 4: ALU opcode.
- `store_data` output XLEN: forwarded rs2 value for stores.
- `rd_addr` output RA_W, `reg_write` output 1, `pc` output XLEN: pass-through to EX/MEM.

## Operation
- Handshake: `in_ready = !out_valid || out_ready`.
- Load: when `in_valid && in_ready && !flush`, all `in_*` fields are registered and `out_valid` is set to 1.
- Drain: when `out_valid && out_ready` and no new load occurs, `out_valid` is cleared to 0.
- Stall: when `out_valid && !out_ready`, every register holds its value and `in_ready` is 0.
- Flush: on a cycle with `flush` asserted, `out_valid` becomes 0 on the next edge, regardless of `in_valid` or stall. The incoming instruction is dropped; flush wins over load.
- Bubble gating: when `out_valid` is 0, `alu_control` is ADD (0), `reg_write` is 0, and the operands are 0.
- Forwarding: applies to each source `s` in {rs1, rs2}, using the registered address.
  - If `exmem_reg_write`, `exmem_rd_addr == s` and `s != 0`, select `exmem_result`.
  - Otherwise, if `memwb_reg_write`, `memwb_rd_addr == s` and `s != 0`, select `memwb_result`.
  - Otherwise, select the registered register-file data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- Forwarding is recomputed every cycle, including during a stall, so a held instruction picks up results that retire while it waits.
- `operand_a` = `in_use_pc` ? `pc` : fwd_rs1.
- `operand_b` = `in_use_imm` ? `imm` : fwd_rs2.
- `store_data` = fwd_rs2, always.
- No arithmetic is performed here. All widths are XLEN with no truncation.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready` is 1.
- Forwarding muxes and output gating are combinational from registered state plus the forwarding inputs. There is no additional cycle.
- `in_ready` is combinational from `out_valid` and `out_ready`. It has no dependency on `in_valid`.
- Reset: asynchronous assertion, synchronous-edge release. While reset is asserted:
  - `out_valid` = 0 and all registered fields = 0.
  - Therefore `operand_a` = `operand_b` = `store_data` = `pc` = 0, `alu_control` = 0, `rd_addr` = 0, `reg_write` = 0.
  - `in_ready` = 1.
- Reset during a stall discards the held instruction. No output glitches to a valid state.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` and `RA_W` constants.
  - ALU opcode localparams ADD … SLTU, used by both this block and the ALU.
  - A forwarding-select enum {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
- One sub-module, `fwd_mux`, instantiated twice (rs1, rs2).
  - Inputs: source address, RF data, both forwarding sources.
  - Outputs: selected value and its select code.
- Everything else (handshake, register bank, operand selection) lives in `id_ex_stage`.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `reg_write`=0, `alu_control`=0 immediately; `in_ready`=1.
- Basic load: accept rs1_data=5, imm=7, `in_use_imm`=1, alu_control=0 → next cycle `out_valid`=1, `operand_a`=5, `operand_b`=7; `pc` matches input.
- Forward priority: rs1=3; exmem (rd=3, 0xAAAA_0000, we=1) and memwb (rd=3, 0x1234, we=1) both hit → `operand_a`=0xAAAA_0000. With exmem we=0 → 0x1234. With rs1=0 and both sources hitting rd=0 → RF value.
- Stall: `out_ready`=0 for 3 cycles while a new `in_valid` pulses → `in_ready`=0, outputs held. Memwb result for rs2 arriving on cycle 2 → `store_data` updates. Release `out_ready` → new instruction loads next edge.
- Flush: `flush`=1 with `in_valid`=1 and `out_valid`=1 → next cycle `out_valid`=0, `reg_write`=0, `alu_control`=0; the dropped instruction never appears.
- Back-to-back: 8 instructions with `out_ready`=1 → 8 consecutive `out_valid` cycles in order, no bubbles.
